// File: rtl/segre_mm_arbiter_if.sv
// Cache-side and memory-side signal bundle of the main-memory arbiter.
// slave = arbiter view, master = caches/memory view.
interface segre_mm_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned LANE_SIZE = 128
);
  logic                 dc_req_i;
  logic                 dc_we_i;
  logic [ADDR_SIZE-1:0] dc_addr_i;
  logic [LANE_SIZE-1:0] dc_data_i;
  logic                 dc_busy_o;
  logic                 dc_rdy_o;
  logic                 dc_err_o;
  logic [LANE_SIZE-1:0] dc_data_o;
  logic                 ic_req_i;
  logic [ADDR_SIZE-1:0] ic_addr_i;
  logic                 ic_busy_o;
  logic                 ic_rdy_o;
  logic                 ic_err_o;
  logic [LANE_SIZE-1:0] ic_data_o;
  logic                 mm_rd_req_o;
  logic                 mm_wr_req_o;
  logic [ADDR_SIZE-1:0] mm_addr_o;
  logic [LANE_SIZE-1:0] mm_data_o;
  logic                 mm_data_rdy_i;
  logic [LANE_SIZE-1:0] mm_data_i;

  modport slave (
    input  dc_req_i, dc_we_i, dc_addr_i, dc_data_i, ic_req_i, ic_addr_i,
           mm_data_rdy_i, mm_data_i,
    output dc_busy_o, dc_rdy_o, dc_err_o, dc_data_o,
           ic_busy_o, ic_rdy_o, ic_err_o, ic_data_o,
           mm_rd_req_o, mm_wr_req_o, mm_addr_o, mm_data_o
  );

  modport master (
    output dc_req_i, dc_we_i, dc_addr_i, dc_data_i, ic_req_i, ic_addr_i,
           mm_data_rdy_i, mm_data_i,
    input  dc_busy_o, dc_rdy_o, dc_err_o, dc_data_o,
           ic_busy_o, ic_rdy_o, ic_err_o, ic_data_o,
           mm_rd_req_o, mm_wr_req_o, mm_addr_o, mm_data_o
  );
endinterface

// File: rtl/segre_mm_arbiter.sv
// Round-robin arbiter of the main-memory port between data and instruction cache.
// Optional WAIT timeout enabled by defining SEGRE_MM_ARB_TIMEOUT_EN.
module segre_mm_arbiter #(
  parameter int unsigned ADDR_SIZE      = 32,
  parameter int unsigned LANE_SIZE      = 128,
  parameter int unsigned LANE_BYTE_BITS = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk_i,
  input logic               rst_i,
  segre_mm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic PORT_DC = 1'b0;
  localparam logic PORT_IC = 1'b1;
  localparam logic [ADDR_SIZE-1:0] ADDR_MASK =
    ~ADDR_SIZE'((64'd1 << LANE_BYTE_BITS) - 64'd1);

  if (TIMEOUT_CYCLES == 0 || LANE_BYTE_BITS >= ADDR_SIZE) begin : g_bad_cfg
    $error("segre_mm_arbiter: invalid TIMEOUT_CYCLES or LANE_BYTE_BITS");
  end

  state_e               r_state, w_next_state;
  logic                 r_dc_pend, r_dc_we, r_ic_pend;
  logic [ADDR_SIZE-1:0] r_dc_addr, r_ic_addr;
  logic [LANE_SIZE-1:0] r_dc_buf;
  logic                 r_owner;   // current owner and last grant
  logic                 r_dc_rdy, r_ic_rdy, r_mm_rd, r_mm_wr;
  logic [ADDR_SIZE-1:0] r_mm_addr;
  logic [LANE_SIZE-1:0] r_mm_data, r_dc_data, r_ic_data;

  logic                 w_sel, w_issue, w_done, w_timeout, w_resp, w_sel_wr;
  logic                 w_dc_rdy, w_ic_rdy, w_mm_rd, w_mm_wr;
  logic [ADDR_SIZE-1:0] w_mm_addr;
  logic [LANE_SIZE-1:0] w_mm_data, w_dc_data, w_ic_data;

  // Tie goes to the port that did not win last time.
  assign w_sel  = r_ic_pend ? (r_dc_pend ? ~r_owner : PORT_IC) : PORT_DC;
  assign w_done = (r_state == S_WAIT) && bus.mm_data_rdy_i;

`ifdef SEGRE_MM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic             r_dc_err, r_ic_err;

  assign w_timeout = (r_state == S_WAIT) && !bus.mm_data_rdy_i &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_dc_err <= 1'b0;
      r_ic_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      r_dc_err <= w_dc_rdy && w_timeout;
      r_ic_err <= w_ic_rdy && w_timeout;
    end
  end

  assign bus.dc_err_o = r_dc_err;
  assign bus.ic_err_o = r_ic_err;
`else
  assign w_timeout    = 1'b0;
  assign bus.dc_err_o = 1'b0;
  assign bus.ic_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (r_dc_pend || r_ic_pend) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (w_done || w_timeout) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_issue   = (r_state == S_IDLE) && (w_next_state == S_ISSUE);
    w_resp    = (r_state == S_WAIT) && (w_next_state == S_RESP);
    w_sel_wr  = (w_sel == PORT_DC) && r_dc_we;
    w_mm_rd   = w_issue && !w_sel_wr;
    w_mm_wr   = w_issue && w_sel_wr;
    w_mm_addr = r_mm_addr;
    w_mm_data = r_mm_data;
    w_dc_rdy  = w_resp && (r_owner == PORT_DC);
    w_ic_rdy  = w_resp && (r_owner == PORT_IC);
    w_dc_data = r_dc_data;
    w_ic_data = r_ic_data;
    if (w_issue) begin
      w_mm_addr = ((w_sel == PORT_DC) ? r_dc_addr : r_ic_addr) & ADDR_MASK;
      w_mm_data = (w_sel == PORT_DC) ? r_dc_buf : '0;
    end
    if (w_dc_rdy) begin
      if (w_timeout)     w_dc_data = '0;
      else if (!r_dc_we) w_dc_data = bus.mm_data_i;
    end
    if (w_ic_rdy) w_ic_data = w_timeout ? '0 : bus.mm_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dc_pend <= 1'b0;
      r_dc_we   <= 1'b0;
      r_dc_addr <= '0;
      r_dc_buf  <= '0;
      r_ic_pend <= 1'b0;
      r_ic_addr <= '0;
      r_owner   <= PORT_IC;
      r_dc_rdy  <= 1'b0;
      r_ic_rdy  <= 1'b0;
      r_mm_rd   <= 1'b0;
      r_mm_wr   <= 1'b0;
      r_mm_addr <= '0;
      r_mm_data <= '0;
      r_dc_data <= '0;
      r_ic_data <= '0;
    end else begin
      if (bus.dc_req_i && !r_dc_pend) begin
        r_dc_pend <= 1'b1;
        r_dc_we   <= bus.dc_we_i;
        r_dc_addr <= bus.dc_addr_i;
        r_dc_buf  <= bus.dc_data_i;
      end else if (r_state == S_RESP && r_owner == PORT_DC) begin
        r_dc_pend <= 1'b0;
      end
      if (bus.ic_req_i && !r_ic_pend) begin
        r_ic_pend <= 1'b1;
        r_ic_addr <= bus.ic_addr_i;
      end else if (r_state == S_RESP && r_owner == PORT_IC) begin
        r_ic_pend <= 1'b0;
      end
      if (w_issue) r_owner <= w_sel;
      r_dc_rdy  <= w_dc_rdy;
      r_ic_rdy  <= w_ic_rdy;
      r_mm_rd   <= w_mm_rd;
      r_mm_wr   <= w_mm_wr;
      r_mm_addr <= w_mm_addr;
      r_mm_data <= w_mm_data;
      r_dc_data <= w_dc_data;
      r_ic_data <= w_ic_data;
    end
  end

  assign bus.dc_busy_o   = r_dc_pend;
  assign bus.ic_busy_o   = r_ic_pend;
  assign bus.dc_rdy_o    = r_dc_rdy;
  assign bus.ic_rdy_o    = r_ic_rdy;
  assign bus.dc_data_o   = r_dc_data;
  assign bus.ic_data_o   = r_ic_data;
  assign bus.mm_rd_req_o = r_mm_rd;
  assign bus.mm_wr_req_o = r_mm_wr;
  assign bus.mm_addr_o   = r_mm_addr;
  assign bus.mm_data_o   = r_mm_data;

endmodule

// File: tb/tb_segre_mm_arbiter.sv
// Directed self-checking bench for segre_mm_arbiter (timeout expectations follow
// SEGRE_MM_ARB_TIMEOUT_EN).
module tb_segre_mm_arbiter;

  localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D3   = 128'hCAFE_F00D_0000_0001_0000_0002_BEEF_0003;
  localparam logic [127:0] D_A5 = {16{8'hA5}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  segre_mm_arbiter_if #(.ADDR_SIZE(32), .LANE_SIZE(128)) bus ();

  segre_mm_arbiter #(
    .ADDR_SIZE(32), .LANE_SIZE(128), .LANE_BYTE_BITS(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs set and outputs read 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({bus.dc_busy_o, bus.ic_busy_o, bus.dc_rdy_o, bus.ic_rdy_o, bus.dc_err_o,
         bus.ic_err_o, bus.mm_rd_req_o, bus.mm_wr_req_o} !== 8'h00) begin
      errors++; $display("FAIL reset_flags: got %b want 00000000", {bus.dc_busy_o,
        bus.ic_busy_o, bus.dc_rdy_o, bus.ic_rdy_o, bus.dc_err_o, bus.ic_err_o,
        bus.mm_rd_req_o, bus.mm_wr_req_o});
    end
    checks++;
    if ({bus.mm_addr_o, bus.mm_data_o, bus.dc_data_o, bus.ic_data_o} !== '0) begin
      errors++; $display("FAIL reset_buses: mm_addr=%h mm_data=%h want 0",
                         bus.mm_addr_o, bus.mm_data_o);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_dc_read;
    bus.dc_req_i = 1'b1; bus.dc_we_i = 1'b0; bus.dc_addr_i = 32'h0000_1234;
    bus.dc_data_i = D2;
    tick;                                            // cycle 1
    bus.dc_req_i = 1'b0;
    checks++;
    if ({bus.dc_busy_o, bus.mm_rd_req_o} !== 2'b10) begin
      errors++; $display("FAIL rd_busy: busy,rd=%b want 10", {bus.dc_busy_o, bus.mm_rd_req_o});
    end
    tick;                                            // cycle 2: ISSUE
    checks++;
    if ({bus.mm_rd_req_o, bus.mm_wr_req_o, bus.mm_addr_o} !== {2'b10, 32'h0000_1230}) begin
      errors++; $display("FAIL rd_issue: rd=%b wr=%b addr=%h want 1 0 00001230",
                         bus.mm_rd_req_o, bus.mm_wr_req_o, bus.mm_addr_o);
    end
    tick;                                            // cycle 3: WAIT
    checks++;
    if ({bus.mm_rd_req_o, bus.mm_addr_o} !== {1'b0, 32'h0000_1230}) begin
      errors++; $display("FAIL rd_strobe_len: rd=%b addr=%h want 0 00001230",
                         bus.mm_rd_req_o, bus.mm_addr_o);
    end
    tick; tick; tick;                                // cycle 6: memory ready
    bus.mm_data_i = D1; bus.mm_data_rdy_i = 1'b1;
    tick;                                            // cycle 7: RESP
    bus.mm_data_rdy_i = 1'b0;
    checks++;
    if ({bus.dc_rdy_o, bus.dc_err_o, bus.ic_rdy_o, bus.ic_busy_o, bus.dc_data_o} !==
        {4'b1000, D1}) begin
      errors++; $display("FAIL rd_resp: rdy,err,ic_rdy,ic_busy=%b data=%h want 1000 %h",
        {bus.dc_rdy_o, bus.dc_err_o, bus.ic_rdy_o, bus.ic_busy_o}, bus.dc_data_o, D1);
    end
    tick;                                            // cycle 8
    checks++;
    if ({bus.dc_rdy_o, bus.dc_busy_o, bus.dc_data_o} !== {2'b00, D1}) begin
      errors++; $display("FAIL rd_after: rdy,busy=%b data=%h want 00 %h",
                         {bus.dc_rdy_o, bus.dc_busy_o}, bus.dc_data_o, D1);
    end
  endtask

  // Both caches request together; first_ic says who must win the tie.
  task automatic test_tie(input bit do_reset, input bit first_ic);
    logic [31:0] a_first, a_second;
    a_first  = first_ic ? 32'h0000_3000 : 32'h0000_2000;
    a_second = first_ic ? 32'h0000_2000 : 32'h0000_3000;
    if (do_reset) begin
      rst = 1'b1; tick; rst = 1'b0;
    end
    bus.dc_req_i = 1'b1; bus.dc_we_i = 1'b0; bus.dc_addr_i = 32'h0000_2008;
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h0000_3004;
    tick;                                            // cycle 1
    bus.dc_req_i = 1'b0; bus.ic_req_i = 1'b0;
    checks++;
    if ({bus.dc_busy_o, bus.ic_busy_o} !== 2'b11) begin
      errors++; $display("FAIL tie_busy: %b want 11", {bus.dc_busy_o, bus.ic_busy_o});
    end
    tick;                                            // cycle 2: first ISSUE
    checks++;
    if ({bus.mm_rd_req_o, bus.mm_addr_o} !== {1'b1, a_first}) begin
      errors++; $display("FAIL tie_first_issue: rd=%b addr=%h want 1 %h",
                         bus.mm_rd_req_o, bus.mm_addr_o, a_first);
    end
    tick;                                            // cycle 3: ready
    bus.mm_data_i = D1; bus.mm_data_rdy_i = 1'b1;
    tick;                                            // cycle 4: first RESP
    bus.mm_data_rdy_i = 1'b0;
    checks++;
    if ({bus.dc_rdy_o, bus.ic_rdy_o, (first_ic ? bus.ic_data_o : bus.dc_data_o)} !==
        {(first_ic ? 2'b01 : 2'b10), D1}) begin
      errors++; $display("FAIL tie_first_resp: dc_rdy,ic_rdy=%b want %b",
                         {bus.dc_rdy_o, bus.ic_rdy_o}, (first_ic ? 2'b01 : 2'b10));
    end
    tick;                                            // cycle 5: IDLE
    checks++;
    if ({bus.mm_rd_req_o, bus.mm_wr_req_o} !== 2'b00) begin
      errors++; $display("FAIL tie_idle_gap: rd,wr=%b want 00", {bus.mm_rd_req_o, bus.mm_wr_req_o});
    end
    tick;                                            // cycle 6: second ISSUE
    checks++;
    if ({bus.mm_rd_req_o, bus.mm_addr_o} !== {1'b1, a_second}) begin
      errors++; $display("FAIL tie_second_issue: rd=%b addr=%h want 1 %h",
                         bus.mm_rd_req_o, bus.mm_addr_o, a_second);
    end
    tick;                                            // cycle 7: ready
    bus.mm_data_i = D2; bus.mm_data_rdy_i = 1'b1;
    tick;                                            // cycle 8: second RESP
    bus.mm_data_rdy_i = 1'b0;
    checks++;
    if ({bus.dc_rdy_o, bus.ic_rdy_o, (first_ic ? bus.dc_data_o : bus.ic_data_o)} !==
        {(first_ic ? 2'b10 : 2'b01), D2}) begin
      errors++; $display("FAIL tie_second_resp: dc_rdy,ic_rdy=%b want %b",
                         {bus.dc_rdy_o, bus.ic_rdy_o}, (first_ic ? 2'b10 : 2'b01));
    end
    tick;
  endtask

  task automatic test_write_back;
    bus.dc_req_i = 1'b1; bus.dc_we_i = 1'b1; bus.dc_addr_i = 32'h8000_00F0;
    bus.dc_data_i = D_A5;
    tick;                                            // cycle 1
    bus.dc_req_i = 1'b0;
    tick;                                            // cycle 2: ISSUE
    checks++;
    if ({bus.mm_wr_req_o, bus.mm_rd_req_o, bus.mm_addr_o, bus.mm_data_o} !==
        {2'b10, 32'h8000_00F0, D_A5}) begin
      errors++; $display("FAIL wb_issue: wr=%b rd=%b addr=%h data=%h want 1 0 800000f0 %h",
        bus.mm_wr_req_o, bus.mm_rd_req_o, bus.mm_addr_o, bus.mm_data_o, D_A5);
    end
    tick;                                            // cycle 3: WAIT, ack
    checks++;
    if ({bus.mm_wr_req_o, bus.mm_rd_req_o, bus.mm_data_o} !== {2'b00, D_A5}) begin
      errors++; $display("FAIL wb_wait: wr=%b rd=%b data=%h want 0 0 %h",
                         bus.mm_wr_req_o, bus.mm_rd_req_o, bus.mm_data_o, D_A5);
    end
    bus.mm_data_i = D3; bus.mm_data_rdy_i = 1'b1;
    tick;                                            // cycle 4: RESP
    bus.mm_data_rdy_i = 1'b0;
    checks++;
    if ({bus.dc_rdy_o, bus.dc_err_o, bus.mm_rd_req_o, bus.ic_rdy_o} !== 4'b1000) begin
      errors++; $display("FAIL wb_resp: rdy,err,mm_rd,ic_rdy=%b want 1000",
        {bus.dc_rdy_o, bus.dc_err_o, bus.mm_rd_req_o, bus.ic_rdy_o});
    end
    tick;                                            // cycle 5
    bus.dc_we_i = 1'b0;
    checks++;
    if ({bus.dc_rdy_o, bus.dc_busy_o} !== 2'b00) begin
      errors++; $display("FAIL wb_after: rdy,busy=%b want 00", {bus.dc_rdy_o, bus.dc_busy_o});
    end
  endtask

  task automatic test_ignore_busy;
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h0000_4444;
    tick;                                            // cycle 1: busy, re-request
    bus.ic_addr_i = 32'h0000_5550; bus.mm_data_rdy_i = 1'b1;
    checks++;
    if (bus.ic_busy_o !== 1'b1) begin
      errors++; $display("FAIL ign_busy: got %b want 1", bus.ic_busy_o);
    end
    tick;                                            // cycle 2: ISSUE
    bus.ic_req_i = 1'b0; bus.mm_data_rdy_i = 1'b0;
    checks++;
    if ({bus.mm_rd_req_o, bus.ic_rdy_o, bus.mm_addr_o} !== {2'b10, 32'h0000_4440}) begin
      errors++; $display("FAIL ign_issue: rd=%b ic_rdy=%b addr=%h want 1 0 00004440",
                         bus.mm_rd_req_o, bus.ic_rdy_o, bus.mm_addr_o);
    end
    tick;                                            // cycle 3: ready
    bus.mm_data_i = D3; bus.mm_data_rdy_i = 1'b1;
    tick;                                            // cycle 4: RESP
    bus.mm_data_rdy_i = 1'b0;
    checks++;
    if ({bus.ic_rdy_o, bus.ic_err_o, bus.ic_data_o} !== {2'b10, D3}) begin
      errors++; $display("FAIL ign_resp: rdy,err=%b data=%h want 10 %h",
                         {bus.ic_rdy_o, bus.ic_err_o}, bus.ic_data_o, D3);
    end
    tick; tick;                                      // cycle 6
    checks++;
    if ({bus.ic_busy_o, bus.mm_rd_req_o} !== 2'b00) begin
      errors++; $display("FAIL ign_no_second: busy,rd=%b want 00", {bus.ic_busy_o, bus.mm_rd_req_o});
    end
  endtask

  task automatic test_reset_mid;
    bus.dc_req_i = 1'b1; bus.dc_we_i = 1'b0; bus.dc_addr_i = 32'h0000_6000;
    tick;                                            // cycle 1
    bus.dc_req_i = 1'b0;
    tick; tick;                                      // cycle 3: WAIT
    rst = 1'b1;
    tick;                                            // cycle 4: after reset
    rst = 1'b0; bus.mm_data_i = D2; bus.mm_data_rdy_i = 1'b1;
    checks++;
    if ({bus.dc_busy_o, bus.dc_rdy_o, bus.mm_rd_req_o, bus.mm_wr_req_o, bus.mm_addr_o,
         bus.dc_data_o, bus.ic_data_o} !== '0) begin
      errors++; $display("FAIL midrst_zero: busy=%b addr=%h dc_data=%h want 0",
                         bus.dc_busy_o, bus.mm_addr_o, bus.dc_data_o);
    end
    tick;                                            // late memory ready ignored
    bus.mm_data_rdy_i = 1'b0;
    checks++;
    if ({bus.dc_rdy_o, bus.dc_busy_o, bus.ic_rdy_o} !== 3'b000) begin
      errors++; $display("FAIL midrst_late_rdy: rdy,busy,ic_rdy=%b want 000",
                         {bus.dc_rdy_o, bus.dc_busy_o, bus.ic_rdy_o});
    end
    bus.dc_req_i = 1'b1; bus.dc_addr_i = 32'h0000_6008;
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h0000_7008;
    tick;
    bus.dc_req_i = 1'b0; bus.ic_req_i = 1'b0;
    tick;                                            // tie resolved to dc again
    checks++;
    if ({bus.mm_rd_req_o, bus.mm_addr_o} !== {1'b1, 32'h0000_6000}) begin
      errors++; $display("FAIL midrst_fresh: rd=%b addr=%h want 1 00006000",
                         bus.mm_rd_req_o, bus.mm_addr_o);
    end
    rst = 1'b1; tick; rst = 1'b0; tick;
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    bus.ic_req_i = 1'b1; bus.ic_addr_i = 32'h0000_9000;
    tick;
    bus.ic_req_i = 1'b0;
    tick;                                            // cycle 2: ISSUE
`ifdef SEGRE_MM_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin                // cycles 3..10: WAIT
      tick;
      if (bus.ic_rdy_o) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL to_early: rdy seen %0d times in WAIT want 0", early);
    end
    tick;                                            // cycle 11: RESP
    checks++;
    if ({bus.ic_rdy_o, bus.ic_err_o, bus.dc_rdy_o, bus.ic_data_o} !== {3'b110, 128'h0}) begin
      errors++; $display("FAIL to_resp: rdy,err,dc_rdy=%b data=%h want 110 0",
                         {bus.ic_rdy_o, bus.ic_err_o, bus.dc_rdy_o}, bus.ic_data_o);
    end
    tick;
    checks++;
    if ({bus.ic_rdy_o, bus.ic_busy_o} !== 2'b00) begin
      errors++; $display("FAIL to_after: rdy,busy=%b want 00", {bus.ic_rdy_o, bus.ic_busy_o});
    end
`else
    for (int i = 0; i < 1000; i++) begin
      tick;
      if (bus.ic_rdy_o || bus.ic_err_o) early++;
    end
    checks++;
    if ({early != 0, bus.ic_busy_o, bus.mm_rd_req_o} !== 3'b010) begin
      errors++; $display("FAIL to_stuck: rdy_seen=%0d busy=%b rd=%b want 0 1 0",
                         early, bus.ic_busy_o, bus.mm_rd_req_o);
    end
    rst = 1'b1; tick; rst = 1'b0; tick;
`endif
  endtask

  initial begin
    bus.dc_req_i = 1'b0; bus.dc_we_i = 1'b0; bus.dc_addr_i = '0; bus.dc_data_i = '0;
    bus.ic_req_i = 1'b0; bus.ic_addr_i = '0;
    bus.mm_data_rdy_i = 1'b0; bus.mm_data_i = '0;
    test_reset;
    test_dc_read;
    test_tie(1'b0, 1'b1);  // last grant was dc, so ic wins
    test_tie(1'b1, 1'b0);  // fresh reset, dc wins
    test_write_back;
    test_ignore_busy;
    test_reset_mid;
    test_timeout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/segre_mm_arbiter.md
Name: segre_mm_arbiter

Overview:
- Arbitrates the single main-memory port between the data cache (line fill and write-back) and the instruction cache (line fill).
- Sits between the cache miss logic and main memory.
- Buffers one outstanding request per requester and grants the port round-robin.
- Sequences each transaction as issue, wait for memory ready, then a one-cycle response to the owning cache.

Parameters:
ADDR_SIZE, 32, address width in bits
LANE_SIZE, 128, cache line / memory data width in bits
LANE_BYTE_BITS, 4, log2(LANE_SIZE/8); count of low address bits cleared on memory addresses
TIMEOUT_CYCLES, 255, maximum WAIT cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
dc_req_i  in  1  data-cache request pulse, accepted only when dc_busy_o=0
dc_we_i  in  1  1 = write-back, 0 = line fill
dc_addr_i  in  ADDR_SIZE  data-cache request address
dc_data_i  in  LANE_SIZE  write-back line
dc_busy_o  out  1  data-cache request pending
dc_rdy_o  out  1  one-cycle completion pulse to the data cache
dc_err_o  out  1  completion was a timeout (qualified by dc_rdy_o)
dc_data_o  out  LANE_SIZE  fill data, valid with dc_rdy_o
ic_req_i  in  1  instruction-cache fill request pulse, accepted only when ic_busy_o=0
ic_addr_i  in  ADDR_SIZE  instruction-cache request address
ic_busy_o  out  1  instruction-cache request pending
ic_rdy_o  out  1  one-cycle completion pulse to the instruction cache
ic_err_o  out  1  completion was a timeout (qualified by ic_rdy_o)
ic_data_o  out  LANE_SIZE  fill data, valid with ic_rdy_o
mm_rd_req_o  out  1  main-memory read strobe
mm_wr_req_o  out  1  main-memory write strobe
mm_addr_o  out  ADDR_SIZE  line-aligned memory address
mm_data_o  out  LANE_SIZE  write data
mm_data_rdy_i  in  1  memory completion (read data valid or write acknowledged)
mm_data_i  in  LANE_SIZE  read data

Behaviour:
- Reset (any cycle, including mid-transaction):
  - All outputs 0; both pending buffers cleared; FSM to IDLE.
  - last_grant = IC, so the data cache wins the first tie after reset.
  - In-flight memory transaction is abandoned; a late mm_data_rdy_i is ignored.
- Request capture:
  - req_i with busy_o=0 latches addr, and for the data cache we and data, at the clock edge.
  - busy_o goes 1 the next cycle and stays 1 through the RESP cycle inclusive.
  - req_i while busy_o=1 is ignored; no state change.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any buffer is pending, select the owner and go to ISSUE.
  - Owner selection when both are pending: the port not equal to last_grant. Otherwise the single pending port.
  - Set last_grant = owner when leaving IDLE.
  - ISSUE (exactly 1 cycle):
    - mm_rd_req_o=1, or mm_wr_req_o=1 for a data-cache write-back.
    - mm_addr_o = {addr[ADDR_SIZE-1:LANE_BYTE_BITS], LANE_BYTE_BITS'b0}.
    - mm_data_o = buffered data.
    - Go to WAIT.
  - WAIT: strobes 0; mm_addr_o/mm_data_o hold their values.
    - On mm_data_rdy_i=1, capture mm_data_i (not for writes) and go to RESP.
  - RESP (1 cycle):
    - Owner rdy_o=1; data_o = captured line. data_o holds its value until the next RESP of that port.
    - Owner buffer cleared at the end of the cycle; go to IDLE.
- mm_data_rdy_i outside WAIT is ignored.
- Minimum latency: req accepted at edge 0; ISSUE in cycle 2; memory ready in cycle 3 gives rdy_o in cycle 4.
- Back-to-back: a second port pending during RESP is issued after one IDLE cycle (RESP → IDLE → ISSUE).
- A requester may re-request in the cycle after its rdy_o.
- Only one memory transaction is in flight at any time; mm_rd_req_o and mm_wr_req_o are never both 1.

Optional Feature:
- Macro: SEGRE_MM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES with mm_data_rdy_i still 0, go to RESP with the owner's err_o=1 and data_o=0.
  - The owner buffer clears normally.
  - mm_data_rdy_i in the same cycle as the timeout takes precedence (normal completion, err_o=0).
- Undefined: no counter; WAIT lasts indefinitely; dc_err_o and ic_err_o are tied to 0.

Test Plan:
- dc read at 0x0000_1234, memory ready after 3 WAIT cycles → mm_addr_o=0x0000_1230, single-cycle mm_rd_req_o, dc_rdy_o 1 cycle with mm_data_i, ic_* idle.
- dc and ic request in the same cycle after reset → dc issued first, ic issued after dc RESP plus 1 IDLE cycle. Repeat with both requesting again → ic first (round-robin alternates).
- dc write-back at 0x8000_00F0 with data 0xA5...A5 → mm_wr_req_o=1, mm_data_o=0xA5...A5, dc_rdy_o pulses on ack, mm_rd_req_o stays 0.
- ic_req_i pulsed again while ic_busy_o=1 with a different address → ignored; only the first address reaches mm_addr_o.
- rst_i asserted during WAIT, then mm_data_rdy_i arrives → no rdy_o; all outputs 0; busy_o=0; next dc request behaves as after a fresh reset.
- With SEGRE_MM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never ready → owner rdy_o=1, err_o=1, data_o=0 after 8 WAIT cycles. Without the macro → still in WAIT after 1000 cycles.
